// File: rtl/cr_tlvp_spl_q_if.sv
// Handshake bundle for the TLV splitter: one input stream and two output streams (PT, USR).
interface cr_tlvp_spl_q_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TYPE_W = 5,
    parameter int unsigned ORD_W  = 8
);
    localparam int unsigned WORD_W = DATA_W + TYPE_W + 3;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;

    logic              pt_valid;
    logic              pt_ready;
    logic [WORD_W-1:0] pt_word;
    logic [ORD_W-1:0]  pt_ordern;

    logic              usr_valid;
    logic              usr_ready;
    logic [WORD_W-1:0] usr_word;
    logic [ORD_W-1:0]  usr_ordern;

    modport master (
        output in_valid, in_word, pt_ready, usr_ready,
        input  in_ready, pt_valid, pt_word, pt_ordern,
        input  usr_valid, usr_word, usr_ordern
    );

    modport slave (
        input  in_valid, in_word, pt_ready, usr_ready,
        output in_ready, pt_valid, pt_word, pt_ordern,
        output usr_valid, usr_word, usr_ordern
    );
endinterface

// File: rtl/cr_tlvp_spl_q.sv
// TLV splitter: per-type action lookup latched at TLV start, routes words to PT/USR FIFOs
// and stamps each word with a per-frame TLV ordinal.

module cr_tlvp_spl_q_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [PW-1:0] cnt_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
endmodule

module cr_tlvp_spl_q #(
    parameter int unsigned NUM_TYPES  = 32,
    parameter int unsigned TYPE_W     = 5,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ORD_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_TYPES-1:0] tlv_parse_action,
    cr_tlvp_spl_q_if.slave         bus,
    output logic                   err_sot
);
    localparam int unsigned WORD_W  = DATA_W + TYPE_W + 3;
    localparam int unsigned ENTRY_W = ORD_W + WORD_W;
    localparam int unsigned PW      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_REP    = 2'd1,
        ACT_MODIFY = 2'd2,
        ACT_DELETE = 2'd3
    } act_e;

    logic              in_tlv_q, in_tlv_d;
    act_e              act_q, act_d;
    logic [ORD_W-1:0]  ord_q, ord_d;
    logic              err_sot_q, err_sot_d;

    logic [TYPE_W-1:0] typen;
    logic              sot, eot, tlast, start, accept;
    act_e              lkp_act, cur_act;
    logic              pt_push, usr_push, pt_pop, usr_pop;
    logic [PW-1:0]     pt_cnt, usr_cnt;
    logic [ENTRY_W-1:0] entry, pt_head, usr_head;

    assign typen = bus.in_word[DATA_W +: TYPE_W];
    assign sot   = bus.in_word[DATA_W + TYPE_W];
    assign eot   = bus.in_word[DATA_W + TYPE_W + 1];
    assign tlast = bus.in_word[DATA_W + TYPE_W + 2];

    // Both FIFOs must have room so PT/USR ordering stays consistent.
    assign bus.in_ready = (pt_cnt < PW'(FIFO_DEPTH)) && (usr_cnt < PW'(FIFO_DEPTH));
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        lkp_act = ACT_PASS;
        for (int unsigned t = 0; t < NUM_TYPES; t++) begin
            if (typen == TYPE_W'(t)) lkp_act = act_e'(tlv_parse_action[2*t +: 2]);
        end
        start   = sot | ~in_tlv_q;
        cur_act = start ? lkp_act : act_q;

        pt_push  = accept & ((cur_act == ACT_PASS) | (cur_act == ACT_REP));
        usr_push = accept & (cur_act != ACT_PASS);
        entry    = {ord_q, bus.in_word};

        in_tlv_d  = in_tlv_q;
        act_d     = act_q;
        ord_d     = ord_q;
        err_sot_d = 1'b0;
        if (accept) begin
            in_tlv_d  = ~eot;
            err_sot_d = ~sot & ~in_tlv_q;
            if (start) act_d = lkp_act;
            // tlast wins over eot; the ordinal skips 0 on wrap.
            if (tlast) begin
                ord_d = ORD_W'(1);
            end else if (eot && (cur_act != ACT_DELETE)) begin
                ord_d = (ord_q == '1) ? ORD_W'(1) : ord_q + ORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_tlv_q  <= 1'b0;
            act_q     <= ACT_PASS;
            ord_q     <= ORD_W'(1);
            err_sot_q <= 1'b0;
        end else begin
            in_tlv_q  <= in_tlv_d;
            act_q     <= act_d;
            ord_q     <= ord_d;
            err_sot_q <= err_sot_d;
        end
    end

    assign err_sot = err_sot_q;

    assign pt_pop  = bus.pt_valid & bus.pt_ready;
    assign usr_pop = bus.usr_valid & bus.usr_ready;

    cr_tlvp_spl_q_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_pt_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pt_push),
        .wdata_i (entry),
        .pop_i   (pt_pop),
        .rdata_o (pt_head),
        .cnt_o   (pt_cnt)
    );

    cr_tlvp_spl_q_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_usr_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (usr_push),
        .wdata_i (entry),
        .pop_i   (usr_pop),
        .rdata_o (usr_head),
        .cnt_o   (usr_cnt)
    );

    assign bus.pt_valid   = (pt_cnt != '0);
    assign bus.pt_word    = pt_head[WORD_W-1:0];
    assign bus.pt_ordern  = pt_head[WORD_W +: ORD_W];
    assign bus.usr_valid  = (usr_cnt != '0);
    assign bus.usr_word   = usr_head[WORD_W-1:0];
    assign bus.usr_ordern = usr_head[WORD_W +: ORD_W];
endmodule
